// File: rtl/ysyx_22041752_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041752_axi_pkg
// Description : Shared definitions for the multi-port AXI arbiter. Contains
//               the FSM state encoding, AXI burst/response codes and a
//               constant-evaluable clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22041752_axi_pkg;

  // One transaction is in flight at a time. Reads go through AR then R,
  // writes through WR then B, and both finish in DONE.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_WR   = 3'd3,
    ST_B    = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Number of bits needed to index 'value' distinct items (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22041752_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041752_rr_picker
// Description : Combinational rotating-priority picker. The port at ptr_i
//               has highest priority, then ptr_i+1 and so on with wrap-around.
//               Tying ptr_i to zero yields plain lowest-index-wins priority.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041752_rr_picker
  import ysyx_22041752_axi_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_WD    = 1
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_WD-1:0]    ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_WD-1:0]    idx_o,
  output logic                 valid_o
);

  // One spare bit so ptr + offset can exceed NUM_PORTS-1 before wrapping.
  localparam int c_SUM_WD = IDX_WD + 1;

  logic [c_SUM_WD-1:0] w_sum;
  logic [IDX_WD-1:0]   w_cand;

  // Walk the ports starting at ptr_i; the first requester found wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_sum = {1'b0, ptr_i} + c_SUM_WD'(k);
      if (w_sum >= c_SUM_WD'(NUM_PORTS)) begin
        w_sum = w_sum - c_SUM_WD'(NUM_PORTS);
      end
      w_cand = w_sum[IDX_WD-1:0];
      if (!valid_o && req_i[w_cand]) begin
        valid_o       = 1'b1;
        idx_o         = w_cand;
        gnt_o[w_cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_22041752_axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041752_axi_rr_arbiter
// Description : Merges NUM_PORTS SRAM-like request ports onto one AXI4
//               master. Single-beat transactions, one outstanding at a time.
//               The granted port index travels on arid/awid/wid and the
//               response code comes back to the requester as req_err_o.
//               Build option YSYX_22041752_ARB_RR_EN: when defined, the grant
//               rotates round-robin; otherwise lowest index wins and the
//               rotation pointer is not built.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041752_axi_rr_arbiter
  import ysyx_22041752_axi_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_WD   = 32,
  parameter int DATA_WD   = 64,
  parameter int ID_WD     = 4,
  localparam int STRB_WD  = DATA_WD / 8
) (
  input  logic                         clk,
  input  logic                         reset,
  // requester side
  input  logic [NUM_PORTS-1:0]         req_en_i,
  input  logic [NUM_PORTS*STRB_WD-1:0] req_wen_i,
  input  logic [NUM_PORTS*ADDR_WD-1:0] req_addr_i,
  input  logic [NUM_PORTS*DATA_WD-1:0] req_wdata_i,
  output logic [NUM_PORTS-1:0]         req_ready_o,
  output logic [DATA_WD-1:0]           req_rdata_o,
  output logic                         req_err_o,
  // AR channel
  output logic [ID_WD-1:0]             arid_o,
  output logic [ADDR_WD-1:0]           araddr_o,
  output logic [7:0]                   arlen_o,
  output logic [2:0]                   arsize_o,
  output logic [1:0]                   arburst_o,
  output logic [1:0]                   arlock_o,
  output logic [3:0]                   arcache_o,
  output logic [2:0]                   arprot_o,
  output logic                         arvalid_o,
  input  logic                         arready_i,
  // R channel
  input  logic [ID_WD-1:0]             rid_i,
  input  logic [DATA_WD-1:0]           rdata_i,
  input  logic [1:0]                   rresp_i,
  input  logic                         rlast_i,
  input  logic                         rvalid_i,
  output logic                         rready_o,
  // AW channel
  output logic [ID_WD-1:0]             awid_o,
  output logic [ADDR_WD-1:0]           awaddr_o,
  output logic [7:0]                   awlen_o,
  output logic [2:0]                   awsize_o,
  output logic [1:0]                   awburst_o,
  output logic [1:0]                   awlock_o,
  output logic [3:0]                   awcache_o,
  output logic [2:0]                   awprot_o,
  output logic                         awvalid_o,
  input  logic                         awready_i,
  // W channel
  output logic [ID_WD-1:0]             wid_o,
  output logic [DATA_WD-1:0]           wdata_o,
  output logic [STRB_WD-1:0]           wstrb_o,
  output logic                         wlast_o,
  output logic                         wvalid_o,
  input  logic                         wready_i,
  // B channel
  input  logic [ID_WD-1:0]             bid_i,
  input  logic [1:0]                   bresp_i,
  input  logic                         bvalid_i,
  output logic                         bready_o
);

  localparam int         c_IDX_WD = clog2(NUM_PORTS);
  localparam logic [2:0] c_AXSIZE = 3'(clog2(STRB_WD));

  state_e               state_q, state_d;
  logic [c_IDX_WD-1:0]  gnt_q, gnt_d;
  logic [ADDR_WD-1:0]   addr_q, addr_d;
  logic [DATA_WD-1:0]   wdata_q, wdata_d;
  logic [STRB_WD-1:0]   wen_q, wen_d;
  logic [DATA_WD-1:0]   rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;

  logic [c_IDX_WD-1:0]  w_ptr;
  logic [NUM_PORTS-1:0] w_pick_gnt;
  logic [c_IDX_WD-1:0]  w_pick_idx;
  logic                 w_pick_valid;
  logic                 w_aw_hs;
  logic                 w_w_hs;
  logic                 w_unused;

  // rid/bid/rlast carry nothing useful with one single-beat transaction in flight.
  assign w_unused = ^{rid_i, bid_i, rlast_i, w_pick_gnt};

  ysyx_22041752_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_WD    (c_IDX_WD)
  ) u_picker (
    .req_i   (req_en_i),
    .ptr_i   (w_ptr),
    .gnt_o   (w_pick_gnt),
    .idx_o   (w_pick_idx),
    .valid_o (w_pick_valid)
  );

`ifdef YSYX_22041752_ARB_RR_EN
  logic [c_IDX_WD-1:0] ptr_q, ptr_d;

  // Next grant search starts just after the port granted last.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && w_pick_valid) begin
      if (w_pick_idx == c_IDX_WD'(NUM_PORTS - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = w_pick_idx + 1'b1;
      end
    end
  end

  // Rotation pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign w_ptr = ptr_q;
`else
  assign w_ptr = '0;
`endif

  // Handshakes on the write address/data channels; each may land first.
  assign w_aw_hs = (state_q == ST_WR) && !aw_done_q && awready_i;
  assign w_w_hs  = (state_q == ST_WR) && !w_done_q  && wready_i;

  // Constant AXI attributes: single beat, full-width, incrementing, unlocked.
  assign arlen_o   = 8'd0;
  assign arsize_o  = c_AXSIZE;
  assign arburst_o = AXI_BURST_INCR;
  assign arlock_o  = 2'b00;
  assign arcache_o = 4'd0;
  assign arprot_o  = 3'd0;
  assign awlen_o   = 8'd0;
  assign awsize_o  = c_AXSIZE;
  assign awburst_o = AXI_BURST_INCR;
  assign awlock_o  = 2'b00;
  assign awcache_o = 4'd0;
  assign awprot_o  = 3'd0;
  assign wlast_o   = 1'b1;

  // Address, data and IDs come straight from the latches, so they stay
  // stable for as long as the matching valid is held.
  assign arid_o   = ID_WD'(gnt_q);
  assign awid_o   = ID_WD'(gnt_q);
  assign wid_o    = ID_WD'(gnt_q);
  assign araddr_o = addr_q;
  assign awaddr_o = addr_q;
  assign wdata_o  = wdata_q;
  assign wstrb_o  = wen_q;

  // Next-state, request latching and per-state channel outputs.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = wen_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    arvalid_o   = 1'b0;
    rready_o    = 1'b0;
    awvalid_o   = 1'b0;
    wvalid_o    = 1'b0;
    bready_o    = 1'b0;
    req_ready_o = '0;
    req_rdata_o = '0;
    req_err_o   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_pick_valid) begin
          gnt_d     = w_pick_idx;
          addr_d    = req_addr_i[int'(w_pick_idx)*ADDR_WD +: ADDR_WD];
          wdata_d   = req_wdata_i[int'(w_pick_idx)*DATA_WD +: DATA_WD];
          wen_d     = req_wen_i[int'(w_pick_idx)*STRB_WD +: STRB_WD];
          rdata_d   = '0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (req_wen_i[int'(w_pick_idx)*STRB_WD +: STRB_WD] != '0) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_AR;
          end
        end
      end
      ST_AR: begin
        arvalid_o = 1'b1;
        if (arready_i) begin
          state_d = ST_R;
        end
      end
      ST_R: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          rdata_d = rdata_i;
          err_d   = (rresp_i != AXI_RESP_OKAY);
          state_d = ST_DONE;
        end
      end
      ST_WR: begin
        awvalid_o = !aw_done_q;
        wvalid_o  = !w_done_q;
        aw_done_d = aw_done_q | w_aw_hs;
        w_done_d  = w_done_q  | w_w_hs;
        if ((aw_done_q || w_aw_hs) && (w_done_q || w_w_hs)) begin
          state_d = ST_B;
        end
      end
      ST_B: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          err_d   = (bresp_i != AXI_RESP_OKAY);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        req_ready_o[gnt_q] = 1'b1;
        req_rdata_o        = rdata_q;
        req_err_o          = err_q;
        state_d            = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and transaction latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wen_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041752_axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22041752_axi_rr_arbiter
// Description : Self-checking bench for ysyx_22041752_axi_rr_arbiter with a
//               configurable-latency AXI slave and a behavioural model of
//               grant order, latency and returned fields.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041752_axi_rr_arbiter;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0]    req_en;
  logic [NP*SW-1:0] req_wen;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP-1:0]    req_ready;
  logic [DW-1:0]    req_rdata;
  logic             req_err;
  logic [IW-1:0] arid, awid, wid, rid, bid;
  logic [AW-1:0] araddr, awaddr;
  logic [7:0]    arlen, awlen;
  logic [2:0]    arsize, awsize, arprot, awprot;
  logic [1:0]    arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]    arcache, awcache;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DW-1:0] rdata, wdata;
  logic [SW-1:0] wstrb;

  ysyx_22041752_axi_rr_arbiter #(
    .NUM_PORTS (NP), .ADDR_WD (AW), .DATA_WD (DW), .ID_WD (IW)
  ) dut (
    .clk (clk), .reset (reset),
    .req_en_i (req_en), .req_wen_i (req_wen), .req_addr_i (req_addr), .req_wdata_i (req_wdata),
    .req_ready_o (req_ready), .req_rdata_o (req_rdata), .req_err_o (req_err),
    .arid_o (arid), .araddr_o (araddr), .arlen_o (arlen), .arsize_o (arsize), .arburst_o (arburst),
    .arlock_o (arlock), .arcache_o (arcache), .arprot_o (arprot), .arvalid_o (arvalid), .arready_i (arready),
    .rid_i (rid), .rdata_i (rdata), .rresp_i (rresp), .rlast_i (rlast), .rvalid_i (rvalid), .rready_o (rready),
    .awid_o (awid), .awaddr_o (awaddr), .awlen_o (awlen), .awsize_o (awsize), .awburst_o (awburst),
    .awlock_o (awlock), .awcache_o (awcache), .awprot_o (awprot), .awvalid_o (awvalid), .awready_i (awready),
    .wid_o (wid), .wdata_o (wdata), .wstrb_o (wstrb), .wlast_o (wlast), .wvalid_o (wvalid), .wready_i (wready),
    .bid_i (bid), .bresp_i (bresp), .bvalid_i (bvalid), .bready_o (bready)
  );

  int vectors = 0;
  int miscompares = 0;

  // Requester model: what each port currently asks for.
  bit            m_pend  [NP];
  logic [AW-1:0] m_addr  [NP];
  logic [DW-1:0] m_wdata [NP];
  logic [SW-1:0] m_wen   [NP];
  int            m_ptr = 0;

  // Slave configuration and observations.
  int cfg_ar_dly = 0, cfg_r_dly = 0, cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0;
  logic [DW-1:0] cfg_rdata = '0;
  logic [1:0]    cfg_resp  = 2'b00;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int n_ar = 0, n_aw = 0, n_w = 0;
  logic [AW-1:0] cap_araddr, cap_awaddr;
  logic [IW-1:0] cap_arid, cap_awid, cap_wid;
  logic [7:0]    cap_arlen, cap_awlen;
  logic [2:0]    cap_arsize, cap_awsize;
  logic [1:0]    cap_arburst, cap_awburst;
  logic [8:0]    cap_arfix, cap_awfix;
  logic [DW-1:0] cap_wdata;
  logic [SW-1:0] cap_wstrb;
  logic          cap_wlast;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // AXI slave: each ready/valid is decided at the falling edge so the DUT
  // sees it at the next rising edge. Delays count visible valid/ready cycles.
  initial begin
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rid = '0; bid = '0; rlast = 1'b1; rdata = '0; rresp = '0; bresp = '0;
    forever begin
      @(negedge clk);
      arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
      if (reset) begin
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else begin
        if (arvalid) begin
          if (ar_cnt >= cfg_ar_dly) begin
            arready = 1; ar_cnt = 0; n_ar++;
            cap_araddr = araddr; cap_arid = arid; cap_arlen = arlen;
            cap_arsize = arsize; cap_arburst = arburst; cap_arfix = {arlock, arcache, arprot};
          end else ar_cnt++;
        end
        if (rready) begin
          if (r_cnt >= cfg_r_dly) begin
            rvalid = 1; rdata = cfg_rdata; rresp = cfg_resp; r_cnt = 0;
          end else r_cnt++;
        end
        if (awvalid) begin
          if (aw_cnt >= cfg_aw_dly) begin
            awready = 1; aw_cnt = 0; n_aw++;
            cap_awaddr = awaddr; cap_awid = awid; cap_awlen = awlen;
            cap_awsize = awsize; cap_awburst = awburst; cap_awfix = {awlock, awcache, awprot};
          end else aw_cnt++;
        end
        if (wvalid) begin
          if (w_cnt >= cfg_w_dly) begin
            wready = 1; w_cnt = 0; n_w++;
            cap_wdata = wdata; cap_wstrb = wstrb; cap_wid = wid; cap_wlast = wlast;
          end else w_cnt++;
        end
        if (bready) begin
          if (b_cnt >= cfg_b_dly) begin
            bvalid = 1; bresp = cfg_resp; b_cnt = 0;
          end else b_cnt++;
        end
      end
    end
  end

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      req_en[p]                = m_pend[p];
      req_wen[p*SW +: SW]      = m_wen[p];
      req_addr[p*AW +: AW]     = m_addr[p];
      req_wdata[p*DW +: DW]    = m_wdata[p];
    end
  endtask

  task automatic new_req(input int p, input bit wr);
    m_pend[p]  = 1'b1;
    m_addr[p]  = $urandom & 32'hFFFF_FFF8;
    m_wdata[p] = {$urandom, $urandom};
    m_wen[p]   = wr ? 8'($urandom_range(1, 255)) : 8'h00;
  endtask

  task automatic set_cfg(input int ar, input int r, input int aw, input int w, input int b,
                         input logic [DW-1:0] rd, input logic [1:0] resp);
    cfg_ar_dly = ar; cfg_r_dly = r; cfg_aw_dly = aw; cfg_w_dly = w; cfg_b_dly = b;
    cfg_rdata = rd; cfg_resp = resp;
  endtask

  // Spec arbitration rule: scan from ptr (round-robin) or from 0 (fixed).
  function automatic int pick();
    for (int k = 0; k < NP; k++) begin
      int p;
`ifdef YSYX_22041752_ARB_RR_EN
      p = (m_ptr + k) % NP;
`else
      p = k;
`endif
      if (m_pend[p]) return p;
    end
    return -1;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_valids"}, {arvalid, awvalid, wvalid, rready, bready}, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_req_err"}, req_err, 0);
    chk({tag, "_req_rdata"}, req_rdata, 0);
    chk({tag, "_addrs"}, {araddr, awaddr}, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_wstrb_ids"}, {wstrb, arid, awid, wid}, 0);
  endtask

  task automatic do_reset();
    for (int p = 0; p < NP; p++) m_pend[p] = 1'b0;
    drive();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
  endtask

  // Run one transaction from an IDLE falling edge and check it completely;
  // returns at the next IDLE falling edge with the winner's request dropped.
  task automatic serve(input bit rnd, output int g_obs);
    int w, lat, ar_hi, aw_hi, w_hi, exp_lat;
    bit done, is_wr;
    logic [NP-1:0] exp_rdy;
    if (rnd) begin
      cfg_ar_dly = $urandom_range(0, 3); cfg_r_dly = $urandom_range(0, 3);
      cfg_aw_dly = $urandom_range(0, 3); cfg_w_dly = $urandom_range(0, 3);
      cfg_b_dly  = $urandom_range(0, 3);
      cfg_rdata  = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0: cfg_resp = 2'b00;
        1: cfg_resp = 2'b10;
        default: cfg_resp = 2'b11;
      endcase
    end
    w = pick();
    is_wr = (m_wen[w] != 0);
    exp_lat = is_wr ? 3 + ((cfg_aw_dly > cfg_w_dly) ? cfg_aw_dly : cfg_w_dly) + cfg_b_dly
                    : 3 + cfg_ar_dly + cfg_r_dly;
    n_ar = 0; n_aw = 0; n_w = 0;
    lat = 0; done = 0; ar_hi = 0; aw_hi = 0; w_hi = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      lat++;
      if (arvalid) begin ar_hi++; chk("araddr_hold", araddr, m_addr[w]); end
      if (awvalid) begin aw_hi++; chk("awaddr_hold", awaddr, m_addr[w]); end
      if (wvalid)  begin w_hi++;  chk("wdata_hold", wdata, m_wdata[w]); end
      if (req_ready != 0) done = 1;
    end
    chk("timeout", done, 1);
    g_obs = -1;
    for (int p = 0; p < NP; p++) if (req_ready[p]) g_obs = p;
    exp_rdy = '0; exp_rdy[w] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("latency", lat, exp_lat);
    chk("req_err", req_err, (cfg_resp != 2'b00));
    chk("req_rdata", req_rdata, is_wr ? 64'd0 : cfg_rdata);
    if (is_wr) begin
      chk("n_ar_wr", n_ar, 0);
      chk("n_aw", n_aw, 1);
      chk("n_w", n_w, 1);
      chk("awvalid_cycles", aw_hi, cfg_aw_dly + 1);
      chk("wvalid_cycles", w_hi, cfg_w_dly + 1);
      chk("awaddr", cap_awaddr, m_addr[w]);
      chk("aw_ids", {cap_awid, cap_wid}, {IW'(w), IW'(w)});
      chk("aw_fixed", {cap_awlen, cap_awsize, cap_awburst, cap_awfix}, {8'd0, 3'd3, 2'b01, 9'd0});
      chk("wdata", cap_wdata, m_wdata[w]);
      chk("wstrb_wlast", {cap_wstrb, cap_wlast}, {m_wen[w], 1'b1});
    end else begin
      chk("n_aw_rd", n_aw + n_w, 0);
      chk("n_ar", n_ar, 1);
      chk("arvalid_cycles", ar_hi, cfg_ar_dly + 1);
      chk("araddr", cap_araddr, m_addr[w]);
      chk("arid", cap_arid, IW'(w));
      chk("ar_fixed", {cap_arlen, cap_arsize, cap_arburst, cap_arfix}, {8'd0, 3'd3, 2'b01, 9'd0});
    end
    m_ptr = (w + 1) % NP;
    m_pend[w] = 1'b0;
    drive();
    @(negedge clk);
    chk("ready_single_pulse", req_ready, 0);
  endtask

  initial begin
    int g, exp_g;
    bit seen_b;
    for (int p = 0; p < NP; p++) begin
      m_pend[p] = 0; m_addr[p] = '0; m_wdata[p] = '0; m_wen[p] = '0;
    end
    drive();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    reset = 1'b0;

    // Single read on port 1, zero-wait slave.
    m_pend[1] = 1; m_addr[1] = 32'h8000_0010; m_wen[1] = 8'h00; m_wdata[1] = '0;
    drive();
    set_cfg(0, 0, 0, 0, 0, 64'hDEAD_BEEF_0000_0001, 2'b00);
    serve(0, g);
    chk("t1_grant", g, 1);

    // Writes on port 0: AW first, W first, both together.
    for (int c = 0; c < 3; c++) begin
      m_pend[0] = 1; m_addr[0] = 32'h8000_0100; m_wen[0] = 8'hFF; m_wdata[0] = 64'h1234;
      drive();
      case (c)
        0: set_cfg(0, 0, 0, 2, 0, '0, 2'b00);
        1: set_cfg(0, 0, 2, 0, 0, '0, 2'b00);
        default: set_cfg(0, 0, 1, 1, 0, '0, 2'b00);
      endcase
      serve(0, g);
      chk("wr_grant", g, 0);
    end

    // SLVERR read followed by an OKAY read.
    new_req(0, 0); drive();
    set_cfg(0, 1, 0, 0, 0, 64'h0BAD_0BAD_0BAD_0BAD, 2'b10);
    serve(0, g);
    new_req(0, 0); drive();
    set_cfg(0, 0, 0, 0, 0, 64'h600D_600D_600D_600D, 2'b00);
    serve(0, g);

    // arready stalled for 5 cycles.
    new_req(1, 0); drive();
    set_cfg(5, 0, 0, 0, 0, 64'h5555_AAAA_5555_AAAA, 2'b00);
    serve(0, g);

    // Ports 0 and 1 request continuously from reset.
    do_reset();
    new_req(0, 0); new_req(1, 0); drive();
    for (int i = 0; i < 6; i++) begin
      serve(1, g);
`ifdef YSYX_22041752_ARB_RR_EN
      exp_g = i % 2;
`else
      exp_g = 0;
`endif
      chk("contend_grant", g, exp_g);
      new_req(g, 0); drive();
    end

    // Randomized traffic; losers keep their request unchanged.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (!m_pend[0] && !m_pend[1]) new_req($urandom_range(0, NP - 1), 1'($urandom_range(0, 1)));
      for (int p = 0; p < NP; p++)
        if (!m_pend[p] && $urandom_range(0, 1) == 1) new_req(p, 1'($urandom_range(0, 1)));
      drive();
      serve(1, g);
    end

    // Reset while waiting in B.
    do_reset();
    new_req(0, 1); drive();
    set_cfg(0, 0, 0, 0, 10, '0, 2'b00);
    seen_b = 0;
    for (int c = 0; c < 20 && !seen_b; c++) begin
      @(negedge clk);
      if (bready) seen_b = 1;
    end
    chk("reach_B", seen_b, 1);
    reset = 1'b1;
    m_pend[0] = 0; drive();
    @(negedge clk);
    chk_reset("midreset");
    reset = 1'b0;
    m_ptr = 0;
    new_req(0, 0); new_req(1, 0); drive();
    serve(1, g);
    chk("post_reset_grant", g, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
